// File: rtl/pcm_arb_pkg.sv
// pcm_arb_pkg: shared state encoding, tag constants and source indices for the PCM FIFO arbiter.
package pcm_arb_pkg;

   typedef enum logic [1:0] {IDLE, TAG, SEND} arb_state_t;

   localparam logic [3:0] TAG_PREFIX = 4'hA;
   localparam int SRC_I2S = 0;
   localparam int SRC_PDM = 1;

   function automatic logic [7:0] tag_byte(input logic src);
      return {TAG_PREFIX, 3'b000, src};
   endfunction

endpackage

// File: rtl/pcm_hold_slot.sv
// pcm_hold_slot: one-sample holding slot with capture/overrun logic and saturating drop counter.
module pcm_hold_slot
   import pcm_arb_pkg::*;
#(
   parameter int DATA_SIZE      = 24,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable_i,
   input  logic                      valid_i,
   input  logic                      grant_i,
   input  logic [DATA_SIZE-1:0]      data_i,
   output logic [DATA_SIZE-1:0]      data_o,
   output logic                      pending_o,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

   logic [DATA_SIZE-1:0]      data_q, data_d;
   logic                      pending_q, pending_d;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
   logic                      take, drop;

   // A grant frees the slot in the same edge, so a coincident valid reloads it.
   always_comb begin
      take      = valid_i && enable_i && (!pending_q || grant_i);
      drop      = valid_i && enable_i && pending_q && !grant_i;
      pending_d = take || (pending_q && !grant_i);
      data_d    = take ? data_i : data_q;
      drop_d    = (drop && !(&drop_q)) ? drop_q + DROP_CNT_WIDTH'(1) : drop_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '0;
         pending_q <= 1'b0;
         drop_q    <= '0;
      end else begin
         data_q    <= data_d;
         pending_q <= pending_d;
         drop_q    <= drop_d;
      end
   end

   assign data_o     = data_q;
   assign pending_o  = pending_q;
   assign drop_cnt_o = drop_q;

endmodule

// File: rtl/pcm_fifo_arbiter.sv
// pcm_fifo_arbiter: round-robin merge of I2S and PDM samples into LSB-first FIFO byte writes.
// Optional PCM_ARB_TAG_EN prefixes each sample with a {4'hA, 3'b000, src} tag byte.
module pcm_fifo_arbiter
   import pcm_arb_pkg::*;
#(
   parameter int DATA_SIZE      = 24,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                src_enable_i,
   input  logic [DATA_SIZE-1:0]      src0_data_i,
   input  logic                      src0_valid_i,
   input  logic [DATA_SIZE-1:0]      src1_data_i,
   input  logic                      src1_valid_i,
   input  logic                      fifo_full_i,
   output logic                      fifo_wr_en_o,
   output logic [7:0]                fifo_write_data_o,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt0_o,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt1_o,
   output logic                      busy_o
);

   localparam int NB = DATA_SIZE / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

   if (DATA_SIZE % 8 != 0 || DATA_SIZE < 8 || DATA_SIZE > 32) begin : g_bad_size
      $error("DATA_SIZE must be a multiple of 8 in 8..32");
   end

   arb_state_t           state_q;
   logic [DATA_SIZE-1:0] shift_q;
   logic [BW-1:0]        b_q;
   logic                 last_grant_q;
   logic [1:0]           pend, gnt;
   logic [DATA_SIZE-1:0] slot0_data, slot1_data;
   logic                 idle;
`ifdef PCM_ARB_TAG_EN
   logic                 src_q;
`endif

   pcm_hold_slot #(.DATA_SIZE(DATA_SIZE), .DROP_CNT_WIDTH(DROP_CNT_WIDTH)) u_slot0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (src_enable_i[SRC_I2S]),
      .valid_i    (src0_valid_i),
      .grant_i    (gnt[SRC_I2S]),
      .data_i     (src0_data_i),
      .data_o     (slot0_data),
      .pending_o  (pend[SRC_I2S]),
      .drop_cnt_o (drop_cnt0_o)
   );

   pcm_hold_slot #(.DATA_SIZE(DATA_SIZE), .DROP_CNT_WIDTH(DROP_CNT_WIDTH)) u_slot1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (src_enable_i[SRC_PDM]),
      .valid_i    (src1_valid_i),
      .grant_i    (gnt[SRC_PDM]),
      .data_i     (src1_data_i),
      .data_o     (slot1_data),
      .pending_o  (pend[SRC_PDM]),
      .drop_cnt_o (drop_cnt1_o)
   );

   // last_grant_q high means PDM went last, so I2S wins the next tie.
   always_comb begin
      idle         = state_q == IDLE;
      gnt[SRC_I2S] = idle && pend[SRC_I2S] && (!pend[SRC_PDM] || last_grant_q);
      gnt[SRC_PDM] = idle && pend[SRC_PDM] && (!pend[SRC_I2S] || !last_grant_q);
      fifo_wr_en_o = !idle && !fifo_full_i;
      busy_o       = !idle || |pend;
`ifdef PCM_ARB_TAG_EN
      fifo_write_data_o = state_q == TAG  ? tag_byte(src_q) :
                          state_q == SEND ? shift_q[7:0] : 8'h00;
`else
      fifo_write_data_o = state_q == SEND ? shift_q[7:0] : 8'h00;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         b_q          <= '0;
         last_grant_q <= 1'b1;
`ifdef PCM_ARB_TAG_EN
         src_q        <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (|gnt) begin
               shift_q      <= gnt[SRC_I2S] ? slot0_data : slot1_data;
               b_q          <= '0;
               last_grant_q <= gnt[SRC_PDM];
`ifdef PCM_ARB_TAG_EN
               src_q        <= gnt[SRC_PDM];
               state_q      <= TAG;
`else
               state_q      <= SEND;
`endif
            end
`ifdef PCM_ARB_TAG_EN
            TAG: if (!fifo_full_i) state_q <= SEND;
`endif
            SEND: if (!fifo_full_i) begin
               shift_q <= shift_q >> 8;
               b_q     <= b_q + BW'(1);
               if (b_q == B_LAST) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcm_fifo_arbiter.sv
// tb_pcm_fifo_arbiter: directed bench with a byte-queue reference model checked every cycle.
module tb_pcm_fifo_arbiter;

   localparam int DW = 24;
   localparam int CW = 16;
`ifdef PCM_ARB_TAG_EN
   localparam int NT = 1;
`else
   localparam int NT = 0;
`endif

   logic          clk = 0, rst_n = 0, v0 = 0, v1 = 0, full = 0;
   logic [1:0]    en = 2'b11;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic          wr_en, busy;
   logic [7:0]    wdata;
   logic [CW-1:0] drop0, drop1;

   always #5 clk = ~clk;

   pcm_fifo_arbiter #(.DATA_SIZE(DW), .DROP_CNT_WIDTH(CW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .src_enable_i      (en),
      .src0_data_i       (d0),
      .src0_valid_i      (v0),
      .src1_data_i       (d1),
      .src1_valid_i      (v1),
      .fifo_full_i       (full),
      .fifo_wr_en_o      (wr_en),
      .fifo_write_data_o (wdata),
      .drop_cnt0_o       (drop0),
      .drop_cnt1_o       (drop1),
      .busy_o            (busy)
   );

   int total = 0, bad = 0, cyc = 0;
   logic [7:0]    mq[$];
   bit            mp[2];
   logic [DW-1:0] md[2];
   int            mdrop[2];
   bit            mlast = 1;
   logic [7:0]    wlog[$];
   int            wcyc[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Model: a queue of bytes still owed to the FIFO; empty queue means the arbiter is free.
   always @(posedge clk or negedge rst_n) begin : model
      int g;
      if (!rst_n) begin
         mq.delete();
         mp = '{0, 0};
         mdrop = '{0, 0};
         mlast = 1;
      end else begin
         g = -1;
         if (mq.size() == 0) begin
            if (mp[0] && mp[1]) g = mlast ? 0 : 1;
            else if (mp[0]) g = 0;
            else if (mp[1]) g = 1;
         end else if (!full) void'(mq.pop_front());
         if (g >= 0) begin
`ifdef PCM_ARB_TAG_EN
            mq.push_back({4'hA, 3'b000, g[0]});
`endif
            for (int i = 0; i < DW / 8; i++) mq.push_back(md[g][8*i +: 8]);
            mp[g] = 0;
            mlast = g[0];
         end
         if (v0 && en[0]) begin
            if (mp[0]) begin if (mdrop[0] < (1 << CW) - 1) mdrop[0]++; end
            else begin mp[0] = 1; md[0] = d0; end
         end
         if (v1 && en[1]) begin
            if (mp[1]) begin if (mdrop[1] < (1 << CW) - 1) mdrop[1]++; end
            else begin mp[1] = 1; md[1] = d1; end
         end
      end
   end

   always @(negedge clk) begin
      chk("wr_en", wr_en, mq.size() > 0 && !full);
      chk("wdata", wdata, mq.size() > 0 ? mq[0] : 8'h00);
      chk("busy", busy, mq.size() > 0 || mp[0] || mp[1]);
      chk("drop0", drop0, mdrop[0]);
      chk("drop1", drop1, mdrop[1]);
      if (wr_en) begin
         wlog.push_back(wdata);
         wcyc.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input bit s0, input logic [DW-1:0] a, input bit s1,
                       input logic [DW-1:0] b, output int c0);
      tick(1);
      v0 = s0; v1 = s1; d0 = a; d1 = b;
      c0 = cyc;
      tick(1);
      v0 = 0; v1 = 0;
   endtask

   task automatic wait_idle(output int c);
      c = -1;
      for (int n = 0; n < 200 && c < 0; n++) begin
         @(negedge clk);
         if (!busy) c = cyc;
      end
      if (c < 0) begin
         total++; bad++;
         $display("FAIL wait_idle: busy still high after 200 cycles");
      end
   endtask

   task automatic wait_write(input int n);
      for (int k = 0; k < 50 && wlog.size() <= n; k++) begin
         @(negedge clk);
         #1;
      end
      if (wlog.size() <= n) begin
         total++; bad++;
         $display("FAIL wait_write: got %0d writes, required more than %0d", wlog.size(), n);
      end
   endtask

   task automatic clear_log;
      wlog.delete();
      wcyc.delete();
   endtask

   task automatic do_reset;
      tick(1);
      rst_n = 0;
      tick(2);
      rst_n = 1;
      clear_log();
   endtask

   task automatic exp_sample(inout logic [7:0] q[$], input logic src,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
`ifdef PCM_ARB_TAG_EN
      q.push_back({4'hA, 3'b000, src});
`else
      if (src) q.push_back(b0);
      else q.push_back(b0);
      void'(q.pop_back());
`endif
      q.push_back(b0);
      q.push_back(b1);
      q.push_back(b2);
   endtask

   task automatic chk_log(input string nm, input logic [7:0] e[$]);
      chk({nm, ".count"}, wlog.size(), e.size());
      for (int i = 0; i < e.size() && i < wlog.size(); i++)
         chk($sformatf("%s.byte%0d", nm, i), wlog[i], e[i]);
   endtask

   function automatic int last_cyc();
      return wcyc.size() > 0 ? wcyc[wcyc.size()-1] : -1;
   endfunction

   initial begin
      int c0, ci;
      logic [7:0] e[$];
      tick(2);
      chk("rst.wr_en", wr_en, 0);
      chk("rst.wdata", wdata, 0);
      chk("rst.busy", busy, 0);
      chk("rst.drop0", drop0, 0);
      chk("rst.drop1", drop1, 0);
      rst_n = 1;
      clear_log();

      send(1, 24'h123456, 0, 24'h0, c0);
      wait_idle(ci);
      e.delete(); exp_sample(e, 0, 8'h56, 8'h34, 8'h12);
      chk_log("single", e);
      chk("single.first_wr_cyc", wcyc.size() > 0 ? wcyc[0] : -1, c0 + 2);
      chk("single.last_wr_cyc", last_cyc(), c0 + 4 + NT);
      chk("single.idle_cyc", ci, c0 + 5 + NT);
      chk("single.drop0", drop0, 0);

      do_reset();
      send(1, 24'hAAAAAA, 1, 24'h555555, c0);
      wait_idle(ci);
      e.delete();
      exp_sample(e, 0, 8'hAA, 8'hAA, 8'hAA);
      exp_sample(e, 1, 8'h55, 8'h55, 8'h55);
      chk_log("pair1", e);
      chk("pair1.first_wr_cyc", wcyc.size() > 0 ? wcyc[0] : -1, c0 + 2);
      chk("pair1.back_to_back", last_cyc(), c0 + 2 + 2 * (3 + NT));
      clear_log();
      send(1, 24'hAAAAAA, 1, 24'h555555, c0);
      wait_idle(ci);
      chk_log("pair2", e);

      clear_log();
      send(1, 24'h123456, 0, 24'h0, c0);
      wait_write(NT);
      tick(1);
      full = 1;
      tick(5);
      full = 0;
      wait_idle(ci);
      e.delete(); exp_sample(e, 0, 8'h56, 8'h34, 8'h12);
      chk_log("stall", e);
      chk("stall.gap", wcyc.size() > NT + 1 ? wcyc[NT+1] - wcyc[NT] : -1, 6);

      clear_log();
      tick(1);
      full = 1;
      send(1, 24'h111111, 0, 24'h0, c0);
      send(1, 24'h222222, 0, 24'h0, c0);
      send(1, 24'h333333, 0, 24'h0, c0);
      chk("overrun.drop0", drop0, 1);
      en = 2'b00;
      send(1, 24'h444444, 1, 24'h777777, c0);
      chk("overrun.disabled_drop0", drop0, 1);
      chk("overrun.disabled_drop1", drop1, 0);
      tick(3);
      chk("overrun.no_write_while_full", wlog.size(), 0);
      en = 2'b11;
      full = 0;
      wait_idle(ci);
      e.delete();
      exp_sample(e, 0, 8'h11, 8'h11, 8'h11);
      exp_sample(e, 0, 8'h22, 8'h22, 8'h22);
      chk_log("overrun", e);

      clear_log();
      send(1, 24'h123456, 0, 24'h0, c0);
      wait_write(NT);
      tick(1);
      rst_n = 0;
      #1;
      chk("midrst.wr_en", wr_en, 0);
      chk("midrst.wdata", wdata, 0);
      chk("midrst.busy", busy, 0);
      chk("midrst.drop0", drop0, 0);
      tick(1);
      rst_n = 1;
      tick(10);
      chk("midrst.no_more_writes", wlog.size(), NT + 1);

      clear_log();
      send(0, 24'h0, 1, 24'hABCDEF, c0);
      wait_idle(ci);
      e.delete(); exp_sample(e, 1, 8'hEF, 8'hCD, 8'hAB);
      chk_log("pdm", e);
      chk("pdm.consecutive", last_cyc() - (wcyc.size() > 0 ? wcyc[0] : 0), 2 + NT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
